instr_dispatch_ctrl: RTL and testbench

INSTR_DISPATCH_CTRL -- requirements
Module: instr_dispatch_ctrl

---
 rtl/instr_dispatch_ctrl.sv | 150 +++++++++++++++
 tb/tb_instr_dispatch_ctrl.sv | 275 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/instr_dispatch_ctrl.sv
// ============================================================================
// Module   : instr_dispatch_ctrl
// Purpose  : Fetches one instruction at a time from the instruction buffer,
//            decodes it and issues commands to the systolic array.
// Revision : 1.0
// ============================================================================
`default_nettype none

module instr_dispatch_ctrl (
  input  logic        clk,
  input  logic        rst,
  input  logic [63:0] instr_in,
  input  logic        instr_valid,
  output logic        instr_pop,
  output logic        op_valid,
  output logic [3:0]  op_code,
  output logic [15:0] op_addr,
  output logic [11:0] op_len,
  input  logic        op_ready,
  input  logic        array_done,
  input  logic        resume,
  output logic        busy,
  output logic        halted,
  output logic        err,
  output logic [15:0] retired
);

  localparam logic [2:0] c_ST_IDLE   = 3'd0;
  localparam logic [2:0] c_ST_FETCH  = 3'd1;
  localparam logic [2:0] c_ST_DECODE = 3'd2;
  localparam logic [2:0] c_ST_ISSUE  = 3'd3;
  localparam logic [2:0] c_ST_WAIT   = 3'd4;
  localparam logic [2:0] c_ST_HALTED = 3'd5;

  localparam logic [3:0] c_OP_NOP  = 4'h0;
  localparam logic [3:0] c_OP_LDW  = 4'h1;
  localparam logic [3:0] c_OP_LDI  = 4'h2;
  localparam logic [3:0] c_OP_MAC  = 4'h3;
  localparam logic [3:0] c_OP_STR  = 4'h4;
  localparam logic [3:0] c_OP_HALT = 4'hF;

  logic [2:0]  r_state;
  logic [2:0]  w_next_state;
  // Only the upper word carries meaning, so only that half is kept.
  logic [31:0] r_instr;
  logic [15:0] r_retired;
  logic        r_err;

  logic [3:0]  w_opc;
  logic [11:0] w_len;
  logic        w_is_nop;
  logic        w_is_halt;
  logic        w_is_cmd;
  logic        w_illegal;
  logic        w_needs_issue;
  logic        w_retire;
  logic        w_unused;

  assign w_unused = ^instr_in[31:0];

  assign w_opc         = r_instr[31:28];
  assign w_len         = r_instr[11:0];
  assign w_is_nop      = (w_opc == c_OP_NOP);
  assign w_is_halt     = (w_opc == c_OP_HALT);
  assign w_is_cmd      = (w_opc == c_OP_LDW) || (w_opc == c_OP_LDI) ||
                         (w_opc == c_OP_MAC) || (w_opc == c_OP_STR);
  assign w_illegal     = !(w_is_nop || w_is_halt || w_is_cmd);
  assign w_needs_issue = w_is_cmd && (w_len != 12'd0);

  // Zero-length commands retire straight out of DECODE like a NOP.
  assign w_retire = ((r_state == c_ST_DECODE) && !w_illegal && !w_needs_issue) ||
                    ((r_state == c_ST_WAIT) && array_done);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= c_ST_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      c_ST_IDLE:   if (instr_valid) w_next_state = c_ST_FETCH;
      c_ST_FETCH:  w_next_state = instr_valid ? c_ST_DECODE : c_ST_IDLE;
      c_ST_DECODE: begin
        if (w_illegal)          w_next_state = c_ST_IDLE;
        else if (w_is_halt)     w_next_state = c_ST_HALTED;
        else if (w_needs_issue) w_next_state = c_ST_ISSUE;
        else                    w_next_state = c_ST_IDLE;
      end
      c_ST_ISSUE:  if (op_ready)   w_next_state = c_ST_WAIT;
      c_ST_WAIT:   if (array_done) w_next_state = c_ST_IDLE;
      c_ST_HALTED: if (resume)     w_next_state = c_ST_IDLE;
      default:     w_next_state = c_ST_IDLE;
    endcase
  end

  always_comb begin
    instr_pop = 1'b0;
    op_valid  = 1'b0;
    op_code   = 4'd0;
    op_addr   = 16'd0;
    op_len    = 12'd0;
    busy      = 1'b0;
    halted    = 1'b0;
    case (r_state)
      c_ST_FETCH: begin
        busy      = 1'b1;
        instr_pop = instr_valid;
      end
      c_ST_DECODE: busy = 1'b1;
      c_ST_ISSUE: begin
        busy     = 1'b1;
        op_valid = 1'b1;
        op_code  = r_instr[31:28];
        op_addr  = r_instr[27:12];
        op_len   = r_instr[11:0];
      end
      c_ST_WAIT:   busy   = 1'b1;
      c_ST_HALTED: halted = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_instr   <= 32'd0;
      r_retired <= 16'd0;
      r_err     <= 1'b0;
    end else begin
      if ((r_state == c_ST_FETCH) && instr_valid) begin
        r_instr <= instr_in[63:32];
      end
      if (w_retire) begin
        r_retired <= r_retired + 16'd1;
      end
      if ((r_state == c_ST_DECODE) && w_illegal) begin
        r_err <= 1'b1;
      end
    end
  end

  assign err     = r_err;
  assign retired = r_retired;

endmodule

`default_nettype wire

// File: tb/tb_instr_dispatch_ctrl.sv
// ============================================================================
// Module   : tb_instr_dispatch_ctrl
// Purpose  : Scoreboard bench for instr_dispatch_ctrl with a buffer/array model.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_instr_dispatch_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic [63:0] instr_in;
  logic        instr_valid;
  logic        instr_pop;
  logic        op_valid;
  logic [3:0]  op_code;
  logic [15:0] op_addr;
  logic [11:0] op_len;
  logic        op_ready;
  logic        array_done;
  logic        resume;
  logic        busy;
  logic        halted;
  logic        err;
  logic [15:0] retired;

  instr_dispatch_ctrl dut (
    .clk(clk), .rst(rst), .instr_in(instr_in), .instr_valid(instr_valid),
    .instr_pop(instr_pop), .op_valid(op_valid), .op_code(op_code),
    .op_addr(op_addr), .op_len(op_len), .op_ready(op_ready),
    .array_done(array_done), .resume(resume), .busy(busy), .halted(halted),
    .err(err), .retired(retired)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;
  int cyc      = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [63:0] buf_q[$];
  logic [31:0] exp_ops[$];
  logic [15:0] model_retired;
  bit          model_err;

  bit pop_seen, accept_seen, outstanding, expect_halted;
  bit prev_opv, prev_stall, prev_accept, prev_b;
  bit gap_en, spur_en, resume_en, noise_en, done_hold;
  int ready_mode, done_cnt, last_pop_cyc, last_opv_rise_cyc, n, rises;
  logic [31:0] held, mon_e;

  task automatic chk(input bit ok, input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (ok) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
  endtask

  // Reference: every legal instruction eventually retires exactly once; only
  // non-zero-length array commands produce an op; illegal ones set err.
  task automatic push(input logic [63:0] ins);
    buf_q.push_back(ins);
    case (ins[63:60])
      4'h0, 4'hF: model_retired = model_retired + 16'd1;
      4'h1, 4'h2, 4'h3, 4'h4: begin
        model_retired = model_retired + 16'd1;
        if (ins[43:32] != 12'd0) exp_ops.push_back(ins[63:32]);
      end
      default: model_err = 1'b1;
    endcase
  endtask

  function automatic logic [63:0] rand_instr();
    logic [3:0]  opc;
    logic [11:0] len;
    int r;
    r = $urandom_range(0, 15);
    if (r < 2)       opc = 4'h0;
    else if (r == 2) opc = 4'hF;
    else if (r == 3) opc = 4'(5 + $urandom_range(0, 9));
    else             opc = 4'(1 + $urandom_range(0, 3));
    len = ($urandom_range(0, 5) == 0) ? 12'd0 : 12'($urandom_range(1, 4095));
    return {opc, 16'($urandom), len, 32'($urandom)};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
    if (pop_seen) begin
      pop_seen = 1'b0;
      if (buf_q.size() > 0) buf_q.delete(0);
    end
    if (accept_seen) begin
      accept_seen = 1'b0;
      outstanding = 1'b1;
      done_cnt    = $urandom_range(0, 4);
    end
    array_done = 1'b0;
    if (outstanding) begin
      if (!done_hold) begin
        if (done_cnt == 0) begin
          array_done  = 1'b1;
          outstanding = 1'b0;
        end else begin
          done_cnt--;
        end
      end
    end else if (spur_en && $urandom_range(0, 7) == 0) begin
      array_done = 1'b1;
    end
    case (ready_mode)
      0:       op_ready = 1'b1;
      1:       op_ready = ($urandom_range(0, 2) != 0);
      default: op_ready = 1'b0;
    endcase
    if (halted) resume = resume_en && ($urandom_range(0, 3) == 0);
    else        resume = noise_en && ($urandom_range(0, 9) == 0);
    instr_valid = (buf_q.size() > 0) && (!gap_en || $urandom_range(0, 3) != 0);
    instr_in    = (buf_q.size() > 0) ? buf_q[0] : {32'($urandom), 32'($urandom)};
  endtask

  task automatic drain(input int budget);
    int k;
    resume_en = 1'b1;
    for (k = 0; k < budget; k++) begin
      if (buf_q.size() == 0 && !outstanding && !busy && !halted && !pop_seen && !accept_seen) break;
      step();
    end
    chk(k < budget, "drain_timeout", 64'(k), 64'(budget));
    chk(retired == model_retired, "retired", retired, model_retired);
    chk(err == model_err, "err", err, model_err);
    chk(exp_ops.size() == 0, "ops_outstanding", exp_ops.size(), 0);
  endtask

  task automatic clear_model();
    buf_q.delete();
    exp_ops.delete();
    outstanding = 0; pop_seen = 0; accept_seen = 0;
    model_retired = 16'd0; model_err = 1'b0;
    instr_valid = 1'b0; array_done = 1'b0; resume = 1'b0;
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      prev_opv = 0; prev_stall = 0; prev_accept = 0; expect_halted = 0;
    end else begin
      if (prev_stall)
        chk(op_valid && {op_code, op_addr, op_len} == held, "op_stable",
            {op_valid, op_code, op_addr, op_len}, {1'b1, held});
      if (prev_accept) chk(!op_valid, "op_drop_after_accept", op_valid, 0);
      if (op_valid && !prev_opv) last_opv_rise_cyc = cyc;
      if (op_valid) begin
        if (exp_ops.size() == 0) chk(1'b0, "unexpected_op", {op_code, op_addr, op_len}, 0);
        else if (op_ready) begin
          mon_e = exp_ops.pop_front();
          chk({op_code, op_addr, op_len} == mon_e, "op_fields", {op_code, op_addr, op_len}, mon_e);
        end
        if (op_ready) accept_seen = 1'b1;
      end else begin
        chk({op_code, op_addr, op_len} == 32'd0, "op_idle_zero", {op_code, op_addr, op_len}, 0);
      end
      prev_stall  = op_valid && !op_ready;
      prev_accept = op_valid && op_ready;
      prev_opv    = op_valid;
      held        = {op_code, op_addr, op_len};
      if (instr_pop) begin
        chk(!expect_halted && instr_valid, "pop_legal", {expect_halted, instr_valid}, 2'b01);
        last_pop_cyc = cyc;
        pop_seen = 1'b1;
        if (instr_in[63:60] == 4'hF) expect_halted = 1'b1;
      end
      if (halted) begin
        chk(expect_halted && !busy, "halted_state", {busy, expect_halted}, 2'b01);
        if (resume) expect_halted = 1'b0;
      end
    end
  end

  initial begin
    rst = 1'b0; instr_in = '0; op_ready = 1'b0;
    gap_en = 0; spur_en = 0; resume_en = 0; noise_en = 0; done_hold = 0; ready_mode = 0;
    clear_model();
    #1;
    chk({instr_pop, op_valid, op_code, op_addr, op_len, busy, halted, err, retired} == 53'd0,
        "reset_outputs", {instr_pop, op_valid, op_code, op_addr, op_len, busy, halted, err, retired}, 0);
    #20 rst = 1'b1;
    step();

    // Single MAC with earliest-possible latency.
    push(64'h3001_0004_0000_0000);
    step();
    n = cyc;
    drain(100);
    chk(last_pop_cyc == n + 1, "pop_latency", 64'(last_pop_cyc - n), 1);
    chk(last_opv_rise_cyc == n + 3, "op_latency", 64'(last_opv_rise_cyc - n), 3);

    // Backpressure: hold op_ready low for five ISSUE cycles.
    ready_mode = 2;
    push(64'h1ABC_D123_0000_0000);
    for (int k = 0; k < 20 && !op_valid; k++) step();
    chk(op_valid, "reach_issue", op_valid, 1);
    repeat (5) step();
    ready_mode = 0;
    drain(100);

    // Asynchronous reset in WAIT, then a late array_done.
    done_hold = 1;
    push(64'h4123_4056_0000_0000);
    for (int k = 0; k < 30 && !outstanding; k++) step();
    chk(outstanding, "reach_wait", outstanding, 1);
    step();
    #2 rst = 1'b0;
    #1;
    chk({instr_pop, op_valid, op_code, op_addr, op_len, busy, halted, err, retired} == 53'd0,
        "reset_async", {instr_pop, op_valid, op_code, op_addr, op_len, busy, halted, err, retired}, 0);
    clear_model();
    done_hold = 0;
    @(posedge clk);
    #4 rst = 1'b1;
    step();
    array_done = 1'b1;
    step();
    step();
    chk(retired == 16'd0, "late_done_ignored", retired, 0);
    push(64'h2777_7888_0000_0000);
    drain(100);

    // HALT followed by a queued MAC.
    resume_en = 0;
    push(64'hF000_0000_0000_0000);
    push(64'h3BEE_F008_0000_0000);
    for (int k = 0; k < 20 && !halted; k++) step();
    chk(halted && !busy, "halt_entered", {halted, busy}, 2'b10);
    repeat (8) step();
    chk(buf_q.size() == 1, "no_pop_halted", buf_q.size(), 1);
    drain(200);

    // NOP, illegal opcode, zero-length LDW.
    push(64'h0000_0000_0000_0000);
    push(64'h7123_4567_0000_0000);
    push(64'h1123_4000_0000_0000);
    drain(100);

    // Randomised traffic.
    gap_en = 1; ready_mode = 1; spur_en = 1; noise_en = 1; resume_en = 1;
    for (int i = 0; i < 80; i++) begin
      push(rand_instr());
      repeat ($urandom_range(0, 4)) step();
    end
    drain(5000);

    // Fresh reset, then a NOP stream.
    gap_en = 0; ready_mode = 0; spur_en = 0; noise_en = 0;
    #2 rst = 1'b0;
    clear_model();
    @(posedge clk);
    #4 rst = 1'b1;
    step();
    for (int i = 0; i < 200; i++) push(64'h0);
    rises = 0; prev_b = 0;
    for (int k = 0; k < 1000 && (buf_q.size() > 0 || busy || pop_seen); k++) begin
      step();
      if (busy && !prev_b) rises++;
      prev_b = busy;
    end
    chk(rises == 200, "busy_toggles", 64'(rises), 200);
    drain(20);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

`default_nettype wire
